// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, reset
// defaults, FSM state encoding and the word-alignment helper.
package inst_fetch_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [DATA_W-1:0] ZeroWord = '0;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT      = 32'hBFC0_0000;
    localparam int unsigned       EXCP_ADEL_BIT_DEFAULT = 0;

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } if_state_e;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Request/acknowledge instruction bus between the fetch stage (master) and
// the instruction memory or cache (slave).
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [INST_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC generation, ibus master, stall hold buffer and
// branch/flush redirects. Optional macro IF_ALIGN_CHECK_EN traps misaligned PCs.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC      = RESET_PC_DEFAULT,
    parameter int unsigned       EXCP_ADEL_BIT = EXCP_ADEL_BIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    inst_fetch_if.master      ibus,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic [DATA_W-1:0] if_excp,
    output logic              if_stall
);

`ifdef IF_ALIGN_CHECK_EN
    localparam logic ALIGN_CHECK = 1'b1;
`else
    localparam logic ALIGN_CHECK = 1'b0;
`endif

    localparam logic [DATA_W-1:0] ADEL_MASK = DATA_W'(1) << EXCP_ADEL_BIT;

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] hold_q, hold_d;
    logic              br_pend_q, br_pend_d;
    logic [ADDR_W-1:0] br_tgt_q, br_tgt_d;
    logic [ADDR_W-1:0] disc_addr_q, disc_addr_d;

    logic              misalign;
    logic              valid;
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
    logic [DATA_W-1:0] excp;
    logic              accept;

    assign misalign = ALIGN_CHECK && (pc_q[1:0] != 2'b00);

    // Outputs are gated by rst so the request drops the moment reset asserts.
    always_comb begin
        req   = 1'b0;
        valid = 1'b0;
        inst  = ZeroWord;
        excp  = ZeroWord;
        if (rst) begin
            unique case (state_q)
                S_REQ: begin
                    if (misalign) begin
                        valid = 1'b1;
                        excp  = ADEL_MASK;
                    end else begin
                        req   = 1'b1;
                        valid = ibus.ack;
                        inst  = ibus.rdata;
                    end
                end
                S_HOLD: begin
                    valid = 1'b1;
                    inst  = hold_q;
                    if (misalign) excp = ADEL_MASK;
                end
                S_DISCARD: begin
                    req = 1'b1;
                end
                default: begin
                    req   = 1'b0;
                    valid = 1'b0;
                end
            endcase
        end
    end

    // The abandoned request keeps its own address because pc already moved on.
    assign addr = (state_q == S_DISCARD) ? disc_addr_q : word_align(pc_q);

    assign ibus.req  = req;
    assign ibus.addr = addr;
    assign if_pc     = pc_q;
    assign if_inst   = inst;
    assign if_excp   = excp;
    assign if_stall  = !valid;

    assign accept = valid && !id_stall && !flush;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_d      = hold_q;
        br_pend_d   = br_pend_q;
        br_tgt_d    = br_tgt_q;
        disc_addr_d = disc_addr_q;

        if (flush) begin
            pc_d      = flush_pc;
            br_pend_d = 1'b0;
            hold_d    = ZeroWord;
            if (state_q == S_DISCARD) begin
                state_d = ibus.ack ? S_REQ : S_DISCARD;
            end else if (state_q == S_REQ && req && !ibus.ack) begin
                state_d     = S_DISCARD;
                disc_addr_d = addr;
            end else begin
                state_d = S_REQ;
            end
        end else if (accept) begin
            if (br_pend_q)      pc_d = br_tgt_q;
            else if (branch_en) pc_d = branch_target;
            else                pc_d = pc_q + 32'd4;
            br_pend_d = 1'b0;
            state_d   = S_REQ;
        end else begin
            if (valid && id_stall && state_q == S_REQ) begin
                hold_d  = inst;
                state_d = S_HOLD;
            end
            if (branch_en) begin
                br_pend_d = 1'b1;
                br_tgt_d  = branch_target;
            end
            if (state_q == S_DISCARD && ibus.ack) begin
                state_d = S_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            hold_q      <= ZeroWord;
            br_pend_q   <= 1'b0;
            br_tgt_q    <= '0;
            disc_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_q      <= hold_d;
            br_pend_q   <= br_pend_d;
            br_tgt_q    <= br_tgt_d;
            disc_addr_q <= disc_addr_d;
        end
    end

    a_addr_stable: assert property (
        @(posedge clk) disable iff (!rst)
        (ibus.req && !ibus.ack) |=> (ibus.req && $stable(ibus.addr))
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a per-cycle vector table for the directed corner cases,
// then a random-stall stream checked against a queue of expected fetches.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_en;
    logic [31:0] branch_target;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] if_excp;
    logic        if_stall;

    inst_fetch_if ibus();

    // Slave returns the inverted address as the instruction word.
    assign ibus.rdata = ibus.ack ? ~ibus.addr : 32'h0BAD_0BAD;

    inst_fetch #(
        .RESET_PC      (32'hBFC0_0000),
        .EXCP_ADEL_BIT (0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_stall      (id_stall),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .ibus          (ibus),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_excp       (if_excp),
        .if_stall      (if_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        id_stall;
        logic        flush;
        logic [31:0] flush_pc;
        logic        branch_en;
        logic [31:0] branch_target;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_stall;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic [31:0] exp_excp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic vec_t mk(
        input logic rs, input logic ids, input logic fl, input logic [31:0] fpc,
        input logic br, input logic [31:0] btgt, input logic ack,
        input logic ereq, input logic [31:0] eaddr, input logic estall,
        input logic [31:0] epc, input logic [31:0] einst, input logic [31:0] eexcp);
        vec_t v;
        v.rst = rs; v.id_stall = ids; v.flush = fl; v.flush_pc = fpc;
        v.branch_en = br; v.branch_target = btgt; v.ack = ack;
        v.exp_req = ereq; v.exp_addr = eaddr; v.exp_stall = estall;
        v.exp_pc = epc; v.exp_inst = einst; v.exp_excp = eexcp;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst           = v.rst;
        id_stall      = v.id_stall;
        flush         = v.flush;
        flush_pc      = v.flush_pc;
        branch_en     = v.branch_en;
        branch_target = v.branch_target;
        ibus.ack      = v.ack;
    endtask

    initial begin
        rst = 1'b0; id_stall = 1'b0; flush = 1'b0; flush_pc = '0;
        branch_en = 1'b0; branch_target = '0; ibus.ack = 1'b0;

        // rst ids fl flush_pc br target ack | req addr stall pc inst excp
        // reset, then zero-wait streaming
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,1, 0,32'h0,1,32'hBFC00000,32'h0,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'hBFC00000,0,32'hBFC00000,~32'hBFC00000,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'hBFC00004,0,32'hBFC00004,~32'hBFC00004,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'hBFC00008,0,32'hBFC00008,~32'hBFC00008,32'h0));
        // ack on 3rd request cycle, two stalled cycles, inst replayed from hold buffer
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,0, 1,32'hBFC0000C,1,32'hBFC0000C,32'h0,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,0, 1,32'hBFC0000C,1,32'hBFC0000C,32'h0,32'h0));
        vecs.push_back(mk(1,1,0,32'h0,0,32'h0,1, 1,32'hBFC0000C,0,32'hBFC0000C,~32'hBFC0000C,32'h0));
        vecs.push_back(mk(1,1,0,32'h0,0,32'h0,0, 0,32'h0,0,32'hBFC0000C,~32'hBFC0000C,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,0, 0,32'h0,0,32'hBFC0000C,~32'hBFC0000C,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'hBFC00010,0,32'hBFC00010,~32'hBFC00010,32'h0));
        // branch under id_stall: delay-slot delivered first, then the target
        vecs.push_back(mk(1,1,0,32'h0,1,32'h80001000,1, 1,32'hBFC00014,0,32'hBFC00014,~32'hBFC00014,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,0, 0,32'h0,0,32'hBFC00014,~32'hBFC00014,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'h80001000,0,32'h80001000,~32'h80001000,32'h0));
        // branch in the same cycle as accept
        vecs.push_back(mk(1,0,0,32'h0,1,32'h80002000,1, 1,32'h80001004,0,32'h80001004,~32'h80001004,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'h80002000,0,32'h80002000,~32'h80002000,32'h0));
        // flush with an outstanding request: old address held until ack, data dropped
        vecs.push_back(mk(1,0,1,32'hBFC00380,0,32'h0,0, 1,32'h80002004,1,32'h80002004,32'h0,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,0, 1,32'h80002004,1,32'hBFC00380,32'h0,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'h80002004,1,32'hBFC00380,32'h0,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'hBFC00380,0,32'hBFC00380,~32'hBFC00380,32'h0));
        // flush beats branch_en and id_stall; pending branch must not survive
        vecs.push_back(mk(1,1,1,32'hBFC00400,1,32'h80003000,1, 1,32'hBFC00384,0,32'hBFC00384,~32'hBFC00384,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'hBFC00400,0,32'hBFC00400,~32'hBFC00400,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'hBFC00404,0,32'hBFC00404,~32'hBFC00404,32'h0));
        // flush while holding
        vecs.push_back(mk(1,1,0,32'h0,0,32'h0,1, 1,32'hBFC00408,0,32'hBFC00408,~32'hBFC00408,32'h0));
        vecs.push_back(mk(1,1,1,32'h80004000,0,32'h0,0, 0,32'h0,0,32'hBFC00408,~32'hBFC00408,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'h80004000,0,32'h80004000,~32'h80004000,32'h0));
        // second flush during discard only moves pc
        vecs.push_back(mk(1,0,1,32'h80005000,0,32'h0,0, 1,32'h80004004,1,32'h80004004,32'h0,32'h0));
        vecs.push_back(mk(1,0,1,32'h80006000,0,32'h0,0, 1,32'h80004004,1,32'h80005000,32'h0,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'h80004004,1,32'h80006000,32'h0,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'h80006000,0,32'h80006000,~32'h80006000,32'h0));
        // pc+4 wraps to zero
        vecs.push_back(mk(1,0,1,32'hFFFFFFFC,0,32'h0,1, 1,32'h80006004,0,32'h80006004,~32'h80006004,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'hFFFFFFFC,0,32'hFFFFFFFC,32'h00000003,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'h00000000,0,32'h00000000,32'hFFFFFFFF,32'h0));
        // second branch before accept overwrites the pending target
        vecs.push_back(mk(1,0,0,32'h0,1,32'h80007000,0, 1,32'h00000004,1,32'h00000004,32'h0,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,1,32'h80008000,0, 1,32'h00000004,1,32'h00000004,32'h0,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'h00000004,0,32'h00000004,~32'h00000004,32'h0));
        // misaligned redirect
        vecs.push_back(mk(1,0,1,32'h80000002,0,32'h0,1, 1,32'h80008000,0,32'h80008000,~32'h80008000,32'h0));
`ifdef IF_ALIGN_CHECK_EN
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 0,32'h0,0,32'h80000002,32'h0,32'h1));
        vecs.push_back(mk(1,0,1,32'h80009000,0,32'h0,1, 0,32'h0,0,32'h80000006,32'h0,32'h1));
`else
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'h80000000,0,32'h80000002,~32'h80000000,32'h0));
        vecs.push_back(mk(1,0,1,32'h80009000,0,32'h0,1, 1,32'h80000004,0,32'h80000006,~32'h80000004,32'h0));
`endif
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'h80009000,0,32'h80009000,~32'h80009000,32'h0));
        // reset asserted mid-request
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,0, 1,32'h80009004,1,32'h80009004,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,0, 0,32'h0,1,32'hBFC00000,32'h0,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,1, 1,32'hBFC00000,0,32'hBFC00000,~32'hBFC00000,32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0) drive(vecs[i]);
            else begin
                @(posedge clk);
                #1 drive(vecs[i]);
            end
            @(negedge clk);
            check("req", i, {31'b0, ibus.req}, {31'b0, vecs[i].exp_req});
            if (vecs[i].exp_req) check("addr", i, ibus.addr, vecs[i].exp_addr);
            check("stall", i, {31'b0, if_stall}, {31'b0, vecs[i].exp_stall});
            check("pc", i, if_pc, vecs[i].exp_pc);
            if (!vecs[i].exp_stall || !vecs[i].rst) begin
                check("inst", i, if_inst, vecs[i].exp_inst);
                check("excp", i, if_excp, vecs[i].exp_excp);
            end
        end

        // Random-latency stream: flush to a base and expect consecutive words.
        @(posedge clk);
        #1;
        flush = 1'b1; flush_pc = 32'h0010_0000; ibus.ack = 1'b0; id_stall = 1'b0;
        for (int k = 0; k < 24; k++) exp_q.push_back(32'h0010_0000 + 32'(k * 4));
        begin
            int cyc = 0;
            while (exp_q.size() > 0 && cyc < 3000) begin
                @(posedge clk);
                #1;
                flush    = 1'b0;
                ibus.ack = ($urandom_range(0, 1) == 1);
                id_stall = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                if (!if_stall && !id_stall) begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("stream_pc", cyc, if_pc, e);
                    check("stream_inst", cyc, if_inst, ~e);
                end
                cyc++;
            end
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL stream_timeout: got %0d outstanding, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
